alu_calc: RTL and testbench
===========================

ALU_CALC -- requirements
Module: alu_calc

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Port clk  input  1  system clock.
REQ-003 Port rst  input  1  synchronous active-high reset.
REQ-004 Port start  input  1  one-cycle request; CPU drives high on entering CALC.
REQ-005 Port opcode  input  3  LOAD=000, ADD=001, ADDI=010, SUB=011, SUBI=100, MUL=101, CLEAR=110, DISPLAY=111.
REQ-006 Port v1RAM  input  16  first operand from memory bank.
REQ-007 Port v2RAM  input  16  second operand from memory bank (ADD/SUB only).
REQ-008 Port imm  input  7  signed immediate from decoder.
REQ-009 Port valorGuardarRAM  output  16  registered result, feeds memory store path.
REQ-010 Port done  output  1  one-cycle pulse: result valid.
REQ-011 Port busy  output  1  high while a MUL is iterating.
REQ-012 Port ovf  output  1  overflow flag for the last completed operation.

Function
REQ-013 FSM states SHALL be IDLE and MULT only.
REQ-014 In IDLE with start=1, opcode, v1RAM, v2RAM and imm SHALL be sampled on that edge; inputs at other times SHALL be ignored.
REQ-015 sext(imm) SHALL denote imm sign-extended to 16 bits; all add/sub results SHALL wrap modulo 2^16.
REQ-016 Single-cycle ops SHALL load valorGuardarRAM and set done=1 on the sampling edge, FSM staying in IDLE (latency 1): LOAD -> sext(imm); ADD -> v1+v2; ADDI -> v1+sext(imm); SUB -> v1-v2; SUBI -> v1-sext(imm); CLEAR -> 0x0000; DISPLAY -> v1.
REQ-017 ovf SHALL be two's-complement signed overflow for ADD/ADDI/SUB/SUBI and 0 for LOAD/CLEAR/DISPLAY.
REQ-018 MUL on the sampling edge SHALL latch multiplicand=v1, multiplier=sext(imm) as unsigned 16-bit, clear a 32-bit accumulator and 5-bit counter, set busy=1 and enter MULT.
REQ-019 Each edge in MULT SHALL process one multiplier bit LSB-first via shift-add and increment the counter.
REQ-020 On the 16th MULT edge, valorGuardarRAM SHALL load accumulator[15:0], ovf SHALL load (accumulator[31:16] != 0), done SHALL be 1, busy SHALL be 0 and FSM SHALL return to IDLE; total MUL latency SHALL be 17 cycles.
REQ-021 done SHALL be high for exactly one cycle per accepted start and SHALL clear on the following edge unless another single-cycle op is accepted.
REQ-022 start while in MULT SHALL be ignored, not queued; input changes during MULT SHALL not affect the result.
REQ-023 Back-to-back starts in IDLE on consecutive cycles SHALL each be accepted, giving done high on consecutive cycles.
REQ-024 valorGuardarRAM and ovf SHALL hold their values between completions.

Reset
REQ-025 rst=1 SHALL force FSM=IDLE, valorGuardarRAM=0x0000, done=0, busy=0, ovf=0, accumulator and counter=0, with priority over start.
REQ-026 rst during MULT SHALL abort the multiply with no done pulse; a start on the first edge after rst deasserts SHALL be accepted.

Verification
REQ-027 ADD, v1RAM=0x7FFF, v2RAM=0x0001 -> valorGuardarRAM=0x8000, ovf=1, done pulse 1 cycle after start.
REQ-028 SUBI, v1RAM=0x0005, imm=7'h7F -> 0x0006, ovf=0; LOAD imm=7'h40 -> 0xFFC0; CLEAR -> 0x0000; DISPLAY v1RAM=0x1234 -> 0x1234.
REQ-029 MUL, v1RAM=0x0003, imm=7'h05 -> busy high 16 cycles, done at cycle 17, result 0x000F, ovf=0.
REQ-030 MUL, v1RAM=0x1000, imm=7'h10 -> result 0x0000, ovf=1.
REQ-031 MUL v1RAM=0x0002, imm=7'h03, second start (ADD) at cycle 5 -> ignored, single done at cycle 17, result 0x0006.
REQ-032 MUL started, rst high at cycle 8 -> all outputs 0 next cycle, no done; ADD 0x0001+0x0001 after rst -> 0x0002.

Source files
------------

// File: rtl/alu_calc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_calc
//  Purpose  : Calculator ALU. Provides single-cycle LOAD/ADD/ADDI/SUB/SUBI/
//             CLEAR/DISPLAY operations and a 16-step shift-add multiply.
//             Produces a registered result with a done pulse, a busy flag
//             and an overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_calc (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic [15:0] v1RAM,
    input  logic [15:0] v2RAM,
    input  logic [6:0]  imm,
    output logic [15:0] valorGuardarRAM,
    output logic        done,
    output logic        busy,
    output logic        ovf
);

    // Opcode encoding
    localparam logic [2:0] c_op_load    = 3'b000;
    localparam logic [2:0] c_op_add     = 3'b001;
    localparam logic [2:0] c_op_addi    = 3'b010;
    localparam logic [2:0] c_op_sub     = 3'b011;
    localparam logic [2:0] c_op_subi    = 3'b100;
    localparam logic [2:0] c_op_mul     = 3'b101;
    localparam logic [2:0] c_op_clear   = 3'b110;
    localparam logic [2:0] c_op_display = 3'b111;

    // FSM state encoding
    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_mult = 1'b1;

    // Index of the last multiplier bit; its edge completes the multiply
    localparam logic [4:0] c_last_step = 5'd15;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;

    logic [15:0] r_result;
    logic        r_done;
    logic        r_busy;
    logic        r_ovf;

    logic [31:0] r_mcand;
    logic [15:0] r_mplier;
    logic [31:0] r_acc;
    logic [4:0]  r_cnt;

    logic [15:0] w_sext;
    logic [15:0] w_operand_b;
    logic [15:0] w_sum;
    logic [15:0] w_diff;
    logic        w_add_ovf;
    logic        w_sub_ovf;
    logic [15:0] w_single_res;
    logic        w_single_ovf;
    logic [31:0] w_acc_next;
    logic        w_mul_last;

    assign w_sext      = {{9{imm[6]}}, imm};
    // Register-register forms use the second memory operand, others the immediate
    assign w_operand_b = ((opcode == c_op_add) || (opcode == c_op_sub)) ? v2RAM : w_sext;
    assign w_sum       = v1RAM + w_operand_b;
    assign w_diff      = v1RAM - w_operand_b;

    // Signed overflow: operands of equal sign (add) or opposite sign (sub)
    // producing a result whose sign differs from the first operand
    assign w_add_ovf = (v1RAM[15] == w_operand_b[15]) && (w_sum[15]  != v1RAM[15]);
    assign w_sub_ovf = (v1RAM[15] != w_operand_b[15]) && (w_diff[15] != v1RAM[15]);

    // Shift-add step: the multiplicand is pre-shifted so bit 0 of the
    // multiplier register always selects the current partial product
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 32'd0);
    assign w_mul_last = (r_cnt == c_last_step);

    // Result and overflow for the single-cycle operations
    always_comb begin
        w_single_res = 16'h0000;
        w_single_ovf = 1'b0;
        case (opcode)
            c_op_load:    w_single_res = w_sext;
            c_op_add:     begin w_single_res = w_sum;  w_single_ovf = w_add_ovf; end
            c_op_addi:    begin w_single_res = w_sum;  w_single_ovf = w_add_ovf; end
            c_op_sub:     begin w_single_res = w_diff; w_single_ovf = w_sub_ovf; end
            c_op_subi:    begin w_single_res = w_diff; w_single_ovf = w_sub_ovf; end
            c_op_clear:   w_single_res = 16'h0000;
            c_op_display: w_single_res = v1RAM;
            default:      w_single_res = 16'h0000;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: only an accepted MUL leaves IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (start && (opcode == c_op_mul)) begin
                    w_state_next = c_st_mult;
                end
            end
            c_st_mult: begin
                if (w_mul_last) begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // Datapath: operand capture, multiply iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 16'h0000;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_ovf    <= 1'b0;
            r_mcand  <= 32'd0;
            r_mplier <= 16'h0000;
            r_acc    <= 32'd0;
            r_cnt    <= 5'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        if (opcode == c_op_mul) begin
                            r_mcand  <= {16'h0000, v1RAM};
                            r_mplier <= w_sext;
                            r_acc    <= 32'd0;
                            r_cnt    <= 5'd0;
                            r_busy   <= 1'b1;
                        end else begin
                            r_result <= w_single_res;
                            r_ovf    <= w_single_ovf;
                            r_done   <= 1'b1;
                        end
                    end
                end
                c_st_mult: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 5'd1;
                    if (w_mul_last) begin
                        r_result <= w_acc_next[15:0];
                        r_ovf    <= |w_acc_next[31:16];
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign valorGuardarRAM = r_result;
    assign done            = r_done;
    assign busy            = r_busy;
    assign ovf             = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_calc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_calc
//  Purpose  : Self-checking testbench for alu_calc with directed vectors and
//             randomized operations against a behavioural arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_calc;

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  opcode;
    logic [15:0] v1RAM;
    logic [15:0] v2RAM;
    logic [6:0]  imm;
    logic [15:0] valorGuardarRAM;
    logic        done;
    logic        busy;
    logic        ovf;

    int n_checks;
    int n_fail;

    alu_calc dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .opcode          (opcode),
        .v1RAM           (v1RAM),
        .v2RAM           (v2RAM),
        .imm             (imm),
        .valorGuardarRAM (valorGuardarRAM),
        .done            (done),
        .busy            (busy),
        .ovf             (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    function automatic logic [15:0] sext(input logic [6:0] im);
        int v;
        v = int'($signed(im));
        return v[15:0];
    endfunction

    // Returns {ovf, result} using plain integer arithmetic
    function automatic logic [16:0] model_op(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [6:0] im);
        int x, y, s;
        logic [31:0] p;
        x = int'($signed(a));
        case (op)
            OP_LOAD:    return {1'b0, sext(im)};
            OP_CLEAR:   return 17'd0;
            OP_DISPLAY: return {1'b0, a};
            OP_MUL: begin
                p = {16'h0000, a} * {16'h0000, sext(im)};
                return {(p[31:16] != 16'h0000), p[15:0]};
            end
            default: begin
                y = ((op == OP_ADD) || (op == OP_SUB)) ? int'($signed(b)) : int'($signed(sext(im)));
                s = ((op == OP_SUB) || (op == OP_SUBI)) ? (x - y) : (x + y);
                return {((s > 32767) || (s < -32768)), s[15:0]};
            end
        endcase
    endfunction

    function automatic logic [2:0] rand_single_op();
        logic [2:0] o;
        o = 3'($urandom_range(0, 7));
        if (o == OP_MUL) o = OP_ADD;
        return o;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b1; opcode = OP_LOAD; imm = 7'h2A;
        v1RAM = 16'h1111; v2RAM = 16'h2222;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({done, busy, ovf, valorGuardarRAM} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_state: got done=%b busy=%b ovf=%b res=%h, want all 0",
                     done, busy, ovf, valorGuardarRAM);
        end
        @(negedge clk); rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if ({done, busy, ovf, valorGuardarRAM} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_idle: got done=%b busy=%b ovf=%b res=%h, want all 0",
                     done, busy, ovf, valorGuardarRAM);
        end
    endtask

    task automatic test_directed_single();
        logic [2:0]  ops [5] = '{OP_ADD, OP_SUBI, OP_LOAD, OP_CLEAR, OP_DISPLAY};
        logic [15:0] a   [5] = '{16'h7FFF, 16'h0005, 16'h0000, 16'hABCD, 16'h1234};
        logic [15:0] b   [5] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        logic [6:0]  ims [5] = '{7'h00, 7'h7F, 7'h40, 7'h11, 7'h00};
        logic [15:0] er  [5] = '{16'h8000, 16'h0006, 16'hFFC0, 16'h0000, 16'h1234};
        logic        eo  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b1; opcode = ops[i]; v1RAM = a[i]; v2RAM = b[i]; imm = ims[i];
            @(posedge clk); #1;
            start = 1'b0; v1RAM = 16'hDEAD; v2RAM = 16'hBEEF; imm = 7'h55;
            n_checks++;
            if ({done, busy, ovf, valorGuardarRAM} !== {1'b1, 1'b0, eo[i], er[i]}) begin
                n_fail++;
                $display("FAIL directed_op%0d: got done=%b busy=%b ovf=%b res=%h, want 1 0 %b %h",
                         i, done, busy, ovf, valorGuardarRAM, eo[i], er[i]);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({done, ovf, valorGuardarRAM} !== {1'b0, eo[i], er[i]}) begin
                n_fail++;
                $display("FAIL directed_hold%0d: got done=%b ovf=%b res=%h, want 0 %b %h",
                         i, done, ovf, valorGuardarRAM, eo[i], er[i]);
            end
        end
    endtask

    task automatic test_random_single();
        logic [16:0] exp;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b1; opcode = rand_single_op();
            v1RAM = 16'($urandom); v2RAM = 16'($urandom); imm = 7'($urandom);
            if (i % 8 == 0) begin v1RAM = 16'h8000; v2RAM = 16'h0001; end
            exp = model_op(opcode, v1RAM, v2RAM, imm);
            @(posedge clk); #1;
            start = 1'b0;
            n_checks++;
            if ({done, busy, ovf, valorGuardarRAM} !== {1'b1, 1'b0, exp}) begin
                n_fail++;
                $display("FAIL random_single op=%0d: got done=%b busy=%b ovf=%b res=%h, want 1 0 %b %h",
                         opcode, done, busy, ovf, valorGuardarRAM, exp[16], exp[15:0]);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL random_single_done_clear: got done=%b, want 0", done);
        end
    endtask

    // Runs one MUL with a bench-supplied expectation; scrambles inputs while busy
    task automatic run_mul(input logic [15:0] a, input logic [6:0] im, input logic [16:0] exp,
                           input string tag);
        int bad;
        @(negedge clk);
        start = 1'b1; opcode = OP_MUL; v1RAM = a; imm = im; v2RAM = 16'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        bad = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            v1RAM = 16'($urandom); imm = 7'($urandom);
            if (k == 4) begin start = 1'b1; opcode = OP_ADD; end else start = 1'b0;
            // k-th cycle of busy: outputs visible before the k-th MULT edge
            if (k <= 16 && (busy !== 1'b1 || done !== 1'b0)) bad++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s_busy: %0d cycles with busy!=1 or done!=0 during multiply", tag, bad);
        end
        n_checks++;
        if ({done, busy, ovf, valorGuardarRAM} !== {1'b1, 1'b0, exp}) begin
            n_fail++;
            $display("FAIL %s_result: got done=%b busy=%b ovf=%b res=%h, want 1 0 %b %h",
                     tag, done, busy, ovf, valorGuardarRAM, exp[16], exp[15:0]);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({done, busy, ovf, valorGuardarRAM} !== {1'b0, 1'b0, exp}) begin
            n_fail++;
            $display("FAIL %s_after: got done=%b busy=%b ovf=%b res=%h, want 0 0 %b %h",
                     tag, done, busy, ovf, valorGuardarRAM, exp[16], exp[15:0]);
        end
    endtask

    task automatic test_mul_directed();
        run_mul(16'h0003, 7'h05, {1'b0, 16'h000F}, "mul_3x5");
        run_mul(16'h1000, 7'h10, {1'b1, 16'h0000}, "mul_ovf");
        run_mul(16'h0002, 7'h03, {1'b0, 16'h0006}, "mul_ignore_start");
    endtask

    task automatic test_mul_random();
        logic [15:0] a;
        logic [6:0]  im;
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom); im = 7'($urandom);
            if (i == 0) a = 16'h00FF;
            run_mul(a, im, model_op(OP_MUL, a, 16'h0, im), "mul_rand");
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'b1; opcode = rand_single_op();
            v1RAM = 16'($urandom); v2RAM = 16'($urandom); imm = 7'($urandom);
            exp = model_op(opcode, v1RAM, v2RAM, imm);
            @(posedge clk); #1;
            n_checks++;
            if ({done, ovf, valorGuardarRAM} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL back_to_back%0d: got done=%b ovf=%b res=%h, want 1 %b %h",
                         i, done, ovf, valorGuardarRAM, exp[16], exp[15:0]);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_end: got done=%b, want 0", done);
        end
    endtask

    task automatic test_reset_during_mul();
        int spurious;
        @(negedge clk);
        start = 1'b1; opcode = OP_MUL; v1RAM = 16'h0007; imm = 7'h09;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({done, busy, ovf, valorGuardarRAM} !== 19'd0) begin
            n_fail++;
            $display("FAIL rst_mid_mul: got done=%b busy=%b ovf=%b res=%h, want all 0",
                     done, busy, ovf, valorGuardarRAM);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b1; opcode = OP_ADD; v1RAM = 16'h0001; v2RAM = 16'h0001;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if ({done, busy, ovf, valorGuardarRAM} !== {1'b1, 1'b0, 1'b0, 16'h0002}) begin
            n_fail++;
            $display("FAIL rst_then_add: got done=%b busy=%b ovf=%b res=%h, want 1 0 0 0002",
                     done, busy, ovf, valorGuardarRAM);
        end
        spurious = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0 || valorGuardarRAM !== 16'h0002) spurious++;
        end
        n_checks++;
        if (spurious != 0) begin
            n_fail++;
            $display("FAIL rst_no_late_done: %0d cycles with stray done/busy/result change, want 0",
                     spurious);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b0; opcode = OP_LOAD;
        v1RAM = 16'h0; v2RAM = 16'h0; imm = 7'h0;
        test_reset();
        test_directed_single();
        test_random_single();
        test_mul_directed();
        test_mul_random();
        test_back_to_back();
        test_reset_during_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
